// File: rtl/nes_pkg.sv
// Shared definitions for the NES controller responder: button indices, FSM encoding, frame size.
package nes_pkg;

  localparam int unsigned NES_BITS = 8;

  localparam int unsigned BTN_A      = 0;
  localparam int unsigned BTN_B      = 1;
  localparam int unsigned BTN_SELECT = 2;
  localparam int unsigned BTN_START  = 3;
  localparam int unsigned BTN_UP     = 4;
  localparam int unsigned BTN_DOWN   = 5;
  localparam int unsigned BTN_LEFT   = 6;
  localparam int unsigned BTN_RIGHT  = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } nes_state_e;

endpackage

// File: rtl/nes_sync_edge.sv
// Multi-flop synchronizer for one asynchronous input with rise/fall detection against the
// previous synchronized value.
module nes_sync_edge #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_async};
      r_prev <= r_sync[STAGES-1];
    end
  end

  assign o_level = r_sync[STAGES-1];
  assign o_rise  = r_sync[STAGES-1] & ~r_prev;
  assign o_fall  = ~r_sync[STAGES-1] & r_prev;

endmodule

// File: rtl/nes_pad_responder.sv
// NES controller emulation: latches synchronized buttons and shifts them out on the host clock.
// Optional autofire on A/B is built when NES_PAD_TURBO_EN is defined (adds the turbo_en port).
module nes_pad_responder
  import nes_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned TURBO_PERIOD   = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NES_BITS-1:0] buttons,
  input  logic                nes_latch,
  input  logic                nes_clk,
  output logic                nes_data,
  output logic                busy,
  output logic                frame_done
`ifdef NES_PAD_TURBO_EN
  ,
  input  logic [1:0]          turbo_en
`endif
);

  localparam int unsigned BIT_W = $clog2(NES_BITS);
  localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic w_latch_lvl, w_latch_rise, w_latch_fall;
  logic w_clk_lvl, w_clk_rise, w_clk_fall;

  nes_sync_edge #(
    .STAGES (SYNC_STAGES)
  ) u_sync_latch (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_async (nes_latch),
    .o_level (w_latch_lvl),
    .o_rise  (w_latch_rise),
    .o_fall  (w_latch_fall)
  );

  nes_sync_edge #(
    .STAGES (SYNC_STAGES)
  ) u_sync_clk (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_async (nes_clk),
    .o_level (w_clk_lvl),
    .o_rise  (w_clk_rise),
    .o_fall  (w_clk_fall)
  );

  logic [NES_BITS-1:0] r_btn_sync [SYNC_STAGES];
  logic [NES_BITS-1:0] w_btn;
  logic [NES_BITS-1:0] w_load;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) r_btn_sync[i] <= '0;
    end else begin
      r_btn_sync[0] <= buttons;
      for (int i = 1; i < int'(SYNC_STAGES); i++) r_btn_sync[i] <= r_btn_sync[i-1];
    end
  end

  assign w_btn = r_btn_sync[SYNC_STAGES-1];

`ifdef NES_PAD_TURBO_EN
  localparam int unsigned TRB_W = (TURBO_PERIOD > 1) ? $clog2(TURBO_PERIOD) : 1;

  logic [TRB_W-1:0] r_turbo_cnt;
  logic             r_phase;
  logic             w_phase_eff;

  // Phase flips on the first latch of each group so the first group reads pressed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_turbo_cnt <= '0;
      r_phase     <= 1'b0;
    end else if (w_latch_rise) begin
      if (r_turbo_cnt == '0) r_phase <= ~r_phase;
      r_turbo_cnt <= (r_turbo_cnt == TRB_W'(TURBO_PERIOD - 1)) ? '0 : r_turbo_cnt + 1'b1;
    end
  end

  assign w_phase_eff = (w_latch_rise && r_turbo_cnt == '0) ? ~r_phase : r_phase;

  always_comb begin
    w_load = w_btn;
    if (!w_phase_eff) begin
      if (turbo_en[0]) w_load[BTN_A] = 1'b0;
      if (turbo_en[1]) w_load[BTN_B] = 1'b0;
    end
  end

  logic w_unused;
  assign w_unused = ^{w_clk_lvl, w_clk_fall};
`else
  assign w_load = w_btn;

  logic w_unused;
  assign w_unused = ^{w_clk_lvl, w_clk_fall, w_latch_rise};
`endif

  nes_state_e          r_state, w_state_nxt;
  logic [NES_BITS-1:0] r_shift, w_shift_nxt;
  logic [BIT_W-1:0]    r_bit, w_bit_nxt;
  logic [TMO_W-1:0]    r_tmo, w_tmo_nxt;
  logic                r_data, w_data_nxt;
  logic                r_done, w_done_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_bit   <= '0;
      r_tmo   <= '0;
      r_data  <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_shift <= w_shift_nxt;
      r_bit   <= w_bit_nxt;
      r_tmo   <= w_tmo_nxt;
      r_data  <= w_data_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_bit_nxt   = r_bit;
    w_tmo_nxt   = r_tmo;
    w_done_nxt  = 1'b0;

    // Latch high overrides everything, including a coincident host clock edge.
    if (w_latch_lvl) begin
      w_state_nxt = LOAD;
      w_shift_nxt = w_load;
      w_bit_nxt   = '0;
      w_tmo_nxt   = '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          w_bit_nxt = '0;
          w_tmo_nxt = '0;
        end
        LOAD: begin
          w_state_nxt = w_latch_fall ? SHIFT : IDLE;
          w_bit_nxt   = '0;
          w_tmo_nxt   = '0;
        end
        SHIFT: begin
          if (w_clk_rise) begin
            w_shift_nxt = {1'b0, r_shift[NES_BITS-1:1]};
            w_tmo_nxt   = '0;
            if (r_bit == BIT_W'(NES_BITS - 1)) begin
              w_state_nxt = IDLE;
              w_bit_nxt   = '0;
              w_done_nxt  = 1'b1;
            end else begin
              w_bit_nxt = r_bit + 1'b1;
            end
          end else if (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            w_state_nxt = IDLE;
            w_bit_nxt   = '0;
            w_tmo_nxt   = '0;
          end else begin
            w_tmo_nxt = r_tmo + 1'b1;
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_bit_nxt   = '0;
          w_tmo_nxt   = '0;
        end
      endcase
    end

    w_data_nxt = (w_state_nxt == IDLE) ? 1'b1 : ~w_shift_nxt[0];
  end

  assign nes_data   = r_data;
  assign busy       = (r_state == SHIFT);
  assign frame_done = r_done;

endmodule

// File: tb/tb_nes_pad_responder.sv
// Scoreboard bench for nes_pad_responder: expected serial bits are queued when a frame is
// requested and compared as the host model clocks them out.
module tb_nes_pad_responder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] buttons = 8'h00;
  logic       nes_latch = 1'b0;
  logic       nes_clk = 1'b0;
  logic       nes_data, busy, frame_done;
`ifdef NES_PAD_TURBO_EN
  logic [1:0] turbo_en = 2'b00;
`endif

  int   n_checks = 0;
  int   n_errors = 0;
  int   fd_cnt = 0;
  logic sb_q[$];

  nes_pad_responder u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .buttons    (buttons),
    .nes_latch  (nes_latch),
    .nes_clk    (nes_clk),
    .nes_data   (nes_data),
    .busy       (busy),
    .frame_done (frame_done)
`ifdef NES_PAD_TURBO_EN
    ,
    .turbo_en   (turbo_en)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_done) fd_cnt++;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic latch_pulse();
    nes_latch = 1'b1;
    tick(6);
    nes_latch = 1'b0;
    tick(6);
  endtask

  task automatic set_buttons(input logic [7:0] b);
    buttons = b;
    tick(4);
  endtask

  task automatic push_frame(input logic [7:0] btn, input int nclk);
    for (int i = 0; i < nclk; i++) sb_q.push_back((i < 8) ? ~btn[i] : 1'b1);
  endtask

  task automatic clock_out(input string tag, input int nclk);
    logic exp;
    check({tag, "_queued"}, sb_q.size(), nclk);
    for (int i = 0; i < nclk; i++) begin
      if (sb_q.size() > 0) begin
        exp = sb_q.pop_front();
        check($sformatf("%s_bit%0d", tag, i), nes_data, exp);
      end
      nes_clk = 1'b1;
      tick(6);
      nes_clk = 1'b0;
      tick(6);
    end
  endtask

  initial begin
    int fd0;
    int cnt;

    // Reset state
    tick(3);
    check("rst_data", nes_data, 1);
    check("rst_busy", busy, 0);
    check("rst_done", frame_done, 0);
    rst_n = 1'b1;

    // Basic read: A only
    set_buttons(8'h01);
    fd0 = fd_cnt;
    latch_pulse();
    check("basic_busy", busy, 1);
    push_frame(8'h01, 8);
    clock_out("basic", 8);
    check("basic_idle", busy, 0);
    check("basic_data", nes_data, 1);
    check("basic_done", fd_cnt - fd0, 1);

    // All pressed, two extra clocks after the frame
    set_buttons(8'hFF);
    fd0 = fd_cnt;
    latch_pulse();
    push_frame(8'hFF, 10);
    clock_out("allp", 10);
    check("allp_done", fd_cnt - fd0, 1);
    check("allp_busy", busy, 0);

    // Abort by re-latch after three clocks
    set_buttons(8'h90);
    fd0 = fd_cnt;
    latch_pulse();
    push_frame(8'h90, 3);
    clock_out("abort1", 3);
    latch_pulse();
    check("abort_nodone", fd_cnt - fd0, 0);
    check("abort_busy", busy, 1);
    push_frame(8'h90, 8);
    clock_out("abort2", 8);
    check("abort_done", fd_cnt - fd0, 1);

    // Host clocks in IDLE are ignored
    fd0 = fd_cnt;
    for (int i = 0; i < 2; i++) begin
      nes_clk = 1'b1;
      tick(6);
      nes_clk = 1'b0;
      tick(6);
    end
    check("idle_busy", busy, 0);
    check("idle_data", nes_data, 1);
    check("idle_done", fd_cnt - fd0, 0);

    // Timeout with no host clocks
    fd0 = fd_cnt;
    nes_latch = 1'b1;
    tick(6);
    nes_latch = 1'b0;
    cnt = 0;
    while (!busy && cnt < 20) begin
      tick(1);
      cnt++;
    end
    check("to_enter", busy, 1);
    cnt = 0;
    while (busy && cnt < 5000) begin
      tick(1);
      cnt++;
    end
    check("to_cycles", cnt, 4096);
    check("to_data", nes_data, 1);
    check("to_done", fd_cnt - fd0, 0);

    // Reset in the middle of a frame
    set_buttons(8'h3C);
    latch_pulse();
    push_frame(8'h3C, 4);
    clock_out("rstmid_pre", 4);
    check("rstmid_before", nes_data, 0);
    fd0 = fd_cnt;
    rst_n = 1'b0;
    tick(1);
    check("rstmid_data", nes_data, 1);
    check("rstmid_busy", busy, 0);
    check("rstmid_fd", frame_done, 0);
    rst_n = 1'b1;
    tick(4);
    check("rstmid_idle", busy, 0);
    check("rstmid_nodone", fd_cnt - fd0, 0);

    // Recovery frame after reset
    set_buttons(8'h5A);
    fd0 = fd_cnt;
    latch_pulse();
    push_frame(8'h5A, 8);
    clock_out("recov", 8);
    check("recov_done", fd_cnt - fd0, 1);

`ifdef NES_PAD_TURBO_EN
    // Autofire on A: four frames pressed, then four released
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    turbo_en = 2'b01;
    set_buttons(8'h01);
    for (int f = 0; f < 8; f++) begin
      latch_pulse();
      push_frame((f < 4) ? 8'h01 : 8'h00, 8);
      clock_out($sformatf("turbo_f%0d", f), 8);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/nes_pad_responder.md
NES_PAD_RESPONDER -- requirements
Module: nes_pad_responder

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: synchronizer depth on nes_latch, nes_clk and buttons, legal range 2..4.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 4096: clk cycles allowed in SHIFT without an nes_clk rising edge.
REQ-003 SHALL have parameter TURBO_PERIOD, default 4: latch pulses per turbo half-period (used only with NES_PAD_TURBO_EN).
REQ-004 SHALL have port clk, input, 1, system clock; all logic is on posedge clk.
REQ-005 SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-006 SHALL have port buttons, input, 8, asynchronous active-high button states {Right,Left,Down,Up,Start,Select,B,A}, with A in bit 0.
REQ-007 SHALL have port nes_latch, input, 1, asynchronous host latch strobe.
REQ-008 SHALL have port nes_clk, input, 1, asynchronous host shift clock.
REQ-009 SHALL have port nes_data, output, 1, registered serial data; 0 = pressed, 1 = released.
REQ-010 SHALL have port busy, output, 1, high while the state is SHIFT.
REQ-011 SHALL have port frame_done, output, 1, one-cycle pulse when the 8th bit is shifted out.
REQ-012 SHALL have port turbo_en, input, 2, {B,A} autofire enables; the port is present only when NES_PAD_TURBO_EN is defined.

Function
REQ-013 SHALL pass nes_latch, nes_clk and buttons through SYNC_STAGES flops, then detect edges by comparing each synchronized signal against its previous-cycle value.
REQ-014 SHALL implement three states:
- IDLE: waiting for a latch.
- LOAD: synchronized latch is high.
- SHIFT: latch has fallen and bits are being clocked out.
REQ-015 SHALL enter LOAD from any state whenever the synchronized latch is high, and reload the 8-bit shift register from the synchronized buttons every cycle while in LOAD.
REQ-016 SHALL drive nes_data from the inverted bit 0 of the shift register (A first) in both LOAD and SHIFT.
REQ-017 SHALL move LOAD->SHIFT on the synchronized latch falling edge, clearing the bit counter to 0.
REQ-018 SHALL, on each synchronized nes_clk rising edge in SHIFT, shift the register right with released-fill (wire value 1) and increment the counter.
REQ-019 SHALL update nes_data at the (SYNC_STAGES+1)th clk rising edge after the external edge is first sampled.
REQ-020 SHALL, on the 8th shift, pulse frame_done for one cycle, go to IDLE, and hold nes_data at 1.
REQ-021 SHALL hold nes_data at 1 in IDLE; nes_clk edges received in IDLE SHALL be ignored.
REQ-022 SHALL give latch priority: a latch rising edge during SHIFT aborts the frame with no frame_done, and an nes_clk edge in the same cycle as latch high is ignored.
REQ-023 SHALL return to IDLE with no frame_done when the SHIFT-state cycle counter reaches TIMEOUT_CYCLES; the counter restarts on every accepted shift.
REQ-024 SHALL make the bit counter and timeout counter saturate or clear, and never wrap, in every state.

Reset
REQ-025 SHALL, while rst_n is low at posedge clk, set: state=IDLE, shift register=0, counters=0, all synchronizer flops=0, nes_data=1, busy=0, frame_done=0.
REQ-026 SHALL, on reset asserted mid-SHIFT, abandon the frame in the same cycle with no frame_done.

Configuration
REQ-027 SHALL, when NES_PAD_TURBO_EN is defined:
- count latch rising edges;
- every TURBO_PERIOD latches, toggle a phase bit;
- while phase=0, force loaded A/B to released where the matching turbo_en bit is 1.
REQ-028 SHALL, when NES_PAD_TURBO_EN is undefined, have no turbo_en port, no turbo counter, and load buttons unmodified.

Structure
REQ-029 SHALL take the following from the shared package nes_pkg:
- button index constants BTN_A=0 .. BTN_RIGHT=7;
- state encoding IDLE/LOAD/SHIFT;
- the NES_BITS=8 constant.
REQ-030 SHALL use one sub-module, nes_sync_edge (parameterized synchronizer plus rise/fall detector), instantiated for nes_latch and nes_clk.

Verification
REQ-031 SHALL verify basic read: buttons=8'b0000_0001 (A), latch pulse, 8 clocks -> nes_data reads 0,1,1,1,1,1,1,1, frame_done pulses once.
REQ-032 SHALL verify all pressed: buttons=8'hFF, 8 clocks then 2 extra -> eight 0s, then 1 for the extra clocks, no second frame_done.
REQ-033 SHALL verify abort: buttons=8'h90, latch re-asserted after 3 clocks -> reload, next read starts with A, no frame_done for the first frame.
REQ-034 SHALL verify timeout: latch then no clocks for 4096 cycles -> busy falls at cycle 4096, nes_data=1, frame_done=0.
REQ-035 SHALL verify reset mid-SHIFT: after 4 clocks, rst_n=0 for 1 cycle -> IDLE, nes_data=1, busy=0.
REQ-036 SHALL verify turbo with NES_PAD_TURBO_EN: turbo_en=2'b01, A held, 8 latches -> A reads pressed for 4 frames then released for 4.
